topk_collector: RTL and testbench
=================================

// Module: topk_collector
// PURPOSE
//  Consumes the scored stream (score, id, valid) produced by the dot-product tensor core.
//  Keeps a running, descending-sorted top-K list of (score, id) for one query scan.
//  When the last score of the scan arrives, it drains the list in rank order over a
//  valid/ready output port, then clears itself for the next query.
// PARAMETERS
//  ID_WIDTH     20  width of vector ID (matches the tensor core id_width)
//  SCORE_WIDTH  32  width of signed dot-product score
//  K             8  number of retained results, >=2
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous reset, active-high
//  in_valid   in   1            score beat present (no stall possible upstream)
//  in_score   in   SCORE_WIDTH  signed dot product
//  in_id      in   ID_WIDTH     vector ID of in_score
//  in_last    in   1            final beat of scan; qualified by in_valid
//  busy       out  1            1 while draining; upstream must not issue
//  out_valid  out  1            result beat present
//  out_ready  in   1            downstream accepts beat
//  out_score  out  SCORE_WIDTH  result score
//  out_id     out  ID_WIDTH     result ID
//  out_rank   out  $clog2(K)    0 = best
//  out_last   out  1            final result beat of this query
//  drop_err   out  1            sticky: a beat arrived while busy
// BEHAVIOUR
//  Reset: state=COLLECT, count=0, all table entries invalid; busy, out_valid, out_last
//   and drop_err are 0; out_score, out_id and out_rank are 0.
//  Reset mid-operation discards the table and any partial drain. No output beat after rst.
//  Table: K slots ordered by score, slot 0 = highest. count holds 0..K filled slots.
//  COLLECT, on in_valid:
//   - p = number of filled slots with score >= in_score (signed compare).
//   - If p<K: write the beat at slot p and shift slots p..K-2 down by one.
//     Slot K-1 is lost. count = min(count+1, K).
//   - If p==K: discard the beat.
//   - Ties: an earlier arrival keeps the better rank. Insertion completes in 1 cycle;
//     a new beat is accepted every cycle.
//   - in_valid & in_last: the beat is inserted, then state=DRAIN next cycle with idx=0.
//     busy=1 and out_valid=1 from that cycle (1-cycle latency from the last beat).
//   - in_last without in_valid is ignored.
//  DRAIN:
//   - out_score and out_id come from slot[idx]. out_rank = idx. out_last = (idx==count-1).
//   - All out_* are held stable while out_valid & !out_ready.
//   - On a handshake with !out_last: idx++.
//   - On a handshake with out_last: next cycle out_valid=0, busy=0, count=0, slots
//     invalid, state=COLLECT. A beat may be accepted in that same next cycle.
//   - count>=1 is guaranteed in DRAIN, because last is always a valid beat.
//  in_valid while busy: the beat is dropped, the table is unchanged, drop_err<=1.
//   drop_err is cleared only by rst.
//  Width: comparisons are signed SCORE_WIDTH. Sized for timing at K<=16 (K comparators
//   in parallel plus one shift mux level).
// STRUCTURE
//  vdpu_pkg: ID_WIDTH/SCORE_WIDTH defaults; typedef struct {valid, score, id} topk_entry_t;
//   state enum {COLLECT, DRAIN}.
//  Sub-module topk_cell (one slot):
//   - inputs: its own entry, the entry above it, the new beat, insert_here, shift_in.
//   - outputs: ge_flag (its entry is valid and score >= new).
//  The top level generates K cells, derives p and the per-slot insert/shift controls
//  from the ge_flag vector, and runs the drain FSM, idx counter, out mux and drop_err.
// TESTING
//  1. Reset asserted for 2 cycles with random inputs -> busy=0, out_valid=0,
//     drop_err=0, then no output.
//  2. Scores 5, -2, 9 (ids 1, 2, 3), last on id 3, out_ready=1 ->
//     (9,3,r0), (5,1,r1), (-2,2,r2,last); first beat 1 cycle after the last input.
//  3. 20 beats, id=i, score=3*i-30, K=8 -> ids 19..12, scores 27..6 descending,
//     out_last on id 12.
//  4. Ties: score 7 with ids 10, 11, 12, then score 8 id 13 -> order 13, 10, 11, 12.
//  5. out_ready pattern 1,0,0,1,0,1... during drain -> no duplicate or skip;
//     values stable while stalled.
//  6. in_valid during DRAIN -> drop_err=1 and output unchanged; the next query starts
//     empty. rst mid-drain -> out_valid=0 next cycle and the table is empty.

Source files
------------

// File: rtl/vdpu_pkg.sv
// Shared types for the vector dot-product unit: default widths, top-K table entry
// and the collector state encoding.
package vdpu_pkg;

    localparam int unsigned ID_WIDTH_DEF    = 20;
    localparam int unsigned SCORE_WIDTH_DEF = 32;

    typedef struct packed {
        logic                              valid;
        logic signed [SCORE_WIDTH_DEF-1:0] score;
        logic        [ID_WIDTH_DEF-1:0]    id;
    } topk_entry_t;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

endpackage

// File: rtl/topk_collector_cell.sv
// One slot of the sorted top-K table: reports whether it outranks the incoming
// beat and computes its own next contents (keep, take the new beat, or take the
// entry from the slot above).
module topk_cell
    import vdpu_pkg::*;
#(
    parameter type entry_t = topk_entry_t
) (
    input  entry_t own,
    input  entry_t above,
    input  entry_t new_beat,
    input  logic   insert_here,
    input  logic   shift_in,
    output entry_t next,
    output logic   ge_flag
);

    // Existing valid entry with an equal or higher score keeps its rank (ties favour earlier arrival)
    always_comb begin
        ge_flag = own.valid && ($signed(own.score) >= $signed(new_beat.score));
    end

    // Next slot contents: insertion wins over shifting, otherwise hold
    always_comb begin
        next = own;
        if (insert_here) begin
            next = new_beat;
        end else if (shift_in) begin
            next = above;
        end
    end

endmodule

// File: rtl/topk_collector.sv
// Running top-K collector: inserts scored beats into a descending sorted table,
// then drains it in rank order over a valid/ready port when the scan ends.
module topk_collector
    import vdpu_pkg::*;
#(
    parameter int unsigned ID_WIDTH    = ID_WIDTH_DEF,
    parameter int unsigned SCORE_WIDTH = SCORE_WIDTH_DEF,
    parameter int unsigned K           = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [SCORE_WIDTH-1:0] in_score,
    input  logic [ID_WIDTH-1:0]    in_id,
    input  logic                   in_last,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SCORE_WIDTH-1:0] out_score,
    output logic [ID_WIDTH-1:0]    out_id,
    output logic [$clog2(K)-1:0]   out_rank,
    output logic                   out_last,
    output logic                   drop_err
);

    localparam int unsigned RW = $clog2(K);
    localparam int unsigned CW = $clog2(K + 1);

    typedef struct packed {
        logic                          valid;
        logic signed [SCORE_WIDTH-1:0] score;
        logic        [ID_WIDTH-1:0]    id;
    } entry_t;

    entry_t         slot     [K];
    entry_t         slot_nxt [K];
    entry_t         above    [K];
    entry_t         beat;
    logic [K-1:0]   ge;
    logic [K-1:0]   ins;
    logic [K-1:0]   shf;
    logic [CW-1:0]  p;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [RW-1:0]  idx;
    logic [RW-1:0]  idx_inc;
    logic           accept;
    logic           clear;
    state_t         state;

    assign accept  = in_valid && (state == COLLECT);
    assign clear   = (state == DRAIN) && out_valid && out_ready && out_last;
    assign idx_inc = idx + 1'b1;

    // Incoming beat as a table entry, and the neighbour each slot shifts from
    always_comb begin
        beat.valid = 1'b1;
        beat.score = in_score;
        beat.id    = in_id;
        above[0]   = '0;
        for (int unsigned k = 1; k < K; k++) begin
            above[k] = slot[k-1];
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_cell
        topk_cell #(.entry_t(entry_t)) u_cell (
            .own         (slot[g]),
            .above       (above[g]),
            .new_beat    (beat),
            .insert_here (ins[g]),
            .shift_in    (shf[g]),
            .next        (slot_nxt[g]),
            .ge_flag     (ge[g])
        );
    end

    // ge is a thermometer code over the sorted table, so its popcount is the insert position
    always_comb begin
        p = '0;
        for (int unsigned k = 0; k < K; k++) begin
            p = p + CW'(ge[k]);
        end
        for (int unsigned k = 0; k < K; k++) begin
            ins[k] = accept && (CW'(k) == p);
            shf[k] = accept && (CW'(k) > p);
        end
        count_nxt = count;
        if (accept && (p < CW'(K)) && (count != CW'(K))) begin
            count_nxt = count + 1'b1;
        end
    end

    // Table and fill count registers; emptied by reset or the final drain handshake
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int unsigned k = 0; k < K; k++) begin
                slot[k] <= '0;
            end
            count <= '0;
        end else begin
            for (int unsigned k = 0; k < K; k++) begin
                slot[k] <= slot_nxt[k];
            end
            count <= count_nxt;
        end
    end

    // Collect/drain FSM with registered output beat, rank index and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_score <= '0;
            out_id    <= '0;
            out_rank  <= '0;
            drop_err  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept && in_last) begin
                        // First beat is taken from the post-insert table so it appears one cycle after last
                        state     <= DRAIN;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        out_score <= slot_nxt[0].score;
                        out_id    <= slot_nxt[0].id;
                        out_rank  <= '0;
                        out_last  <= (count_nxt == CW'(1));
                    end
                end
                DRAIN: begin
                    if (in_valid) begin
                        drop_err <= 1'b1;
                    end
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= COLLECT;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_score <= '0;
                            out_id    <= '0;
                            out_rank  <= '0;
                            idx       <= '0;
                        end else begin
                            idx       <= idx_inc;
                            out_score <= slot[idx_inc].score;
                            out_id    <= slot[idx_inc].id;
                            out_rank  <= idx_inc;
                            out_last  <= (CW'(idx_inc) == (count - CW'(1)));
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_topk_collector.sv
// Directed self-checking bench for topk_collector with an expected-result queue.
module tb_topk_collector;

    localparam int unsigned SW = 32;
    localparam int unsigned IW = 20;
    localparam int unsigned K  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [SW-1:0] in_score;
    logic [IW-1:0] in_id;
    logic          in_last;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_score;
    logic [IW-1:0] out_id;
    logic [2:0]    out_rank;
    logic          out_last;
    logic          drop_err;

    topk_collector #(.ID_WIDTH(IW), .SCORE_WIDTH(SW), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_score  (in_score),
        .in_id     (in_id),
        .in_last   (in_last),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_score (out_score),
        .out_id    (out_id),
        .out_rank  (out_rank),
        .out_last  (out_last),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] s;
        logic [IW-1:0] id;
        logic [2:0]    r;
        logic          l;
    } exp_t;

    exp_t expq[$];
    int   mscore[$];
    int   mid[$];
    bit   auto_exp;
    int   checks = 0;
    int   fails  = 0;
    int   pat[6] = '{1, 0, 0, 1, 0, 1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int s, input int id, input int r, input bit l);
        exp_t e;
        e.s  = s;
        e.id = id;
        e.r  = r[2:0];
        e.l  = l;
        expq.push_back(e);
    endtask

    // Reference top-K list: stable insertion below all entries with score >= new
    task automatic model_insert(input int s, input int id);
        int p = 0;
        foreach (mscore[i]) if (mscore[i] >= s) p++;
        if (p < K) begin
            mscore.insert(p, s);
            mid.insert(p, id);
            if (mscore.size() > K) begin
                void'(mscore.pop_back());
                void'(mid.pop_back());
            end
        end
    endtask

    task automatic send(input int s, input int id, input bit last);
        in_valid = 1'b1;
        in_score = s;
        in_id    = id[IW-1:0];
        in_last  = last;
        model_insert(s, id);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) begin
            if (auto_exp) begin
                for (int r = 0; r < mscore.size(); r++) begin
                    push_exp(mscore[r], mid[r], r, r == mscore.size() - 1);
                end
            end
            mscore.delete();
            mid.delete();
        end
    endtask

    // mode 0: always ready; mode 1: ready follows pat[]
    task automatic drain(input int mode, input int budget);
        int            cyc = 0;
        bit            done = 0;
        bit            stalled = 0;
        logic [SW-1:0] hs;
        logic [IW-1:0] hi;
        logic [2:0]    hr;
        logic          hl;
        exp_t          e;
        while (!done && cyc < budget) begin
            out_ready = (mode == 0) ? 1'b1 : (pat[cyc % 6] != 0);
            @(negedge clk);
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_score", out_score, hs);
                check("stall_id", out_id, hi);
                check("stall_rank", out_rank, hr);
                check("stall_last", out_last, hl);
            end
            if (out_valid) begin
                if (out_ready) begin
                    stalled = 0;
                    if (expq.size() == 0) begin
                        check("unexpected_beat", out_id, '1);
                        done = 1;
                    end else begin
                        e = expq.pop_front();
                        check("beat_score", out_score, e.s);
                        check("beat_id", out_id, e.id);
                        check("beat_rank", out_rank, e.r);
                        check("beat_last", out_last, e.l);
                        done = out_last;
                    end
                end else begin
                    stalled = 1;
                    hs = out_score; hi = out_id; hr = out_rank; hl = out_last;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_timeout", done, 1);
        check("drain_idle_valid", out_valid, 0);
        check("drain_idle_busy", busy, 0);
        check("drain_queue_empty", expq.size(), 0);
    endtask

    initial begin
        logic [SW-1:0] hs;
        logic [IW-1:0] hi;
        auto_exp  = 1'b1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_score  = '0;
        in_id     = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom);
            in_last   = 1'($urandom);
            in_score  = $urandom;
            in_id     = IW'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_drop", drop_err, 0);
        check("rst_last", out_last, 0);
        check("rst_score", out_score, 0);
        check("rst_id", out_id, 0);
        check("rst_rank", out_rank, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_output", out_valid, 0);
        end
        @(posedge clk); #1;

        // 2: small query, one-cycle latency
        auto_exp = 1'b0;
        send(5, 1, 0);
        send(-2, 2, 0);
        send(9, 3, 1);
        check("t2_latency_valid", out_valid, 1);
        check("t2_latency_busy", busy, 1);
        push_exp(9, 3, 0, 0);
        push_exp(5, 1, 1, 0);
        push_exp(-2, 2, 2, 1);
        drain(0, 50);

        // 3: overflow, keep best K
        for (int i = 0; i < 20; i++) send(3 * i - 30, i, i == 19);
        for (int r = 0; r < 8; r++) push_exp(3 * (19 - r) - 30, 19 - r, r, r == 7);
        drain(0, 50);

        // 4: ties keep arrival order
        send(7, 10, 0);
        send(7, 11, 0);
        send(7, 12, 0);
        send(8, 13, 1);
        push_exp(8, 13, 0, 0);
        push_exp(7, 10, 1, 0);
        push_exp(7, 11, 2, 0);
        push_exp(7, 12, 3, 1);
        drain(0, 50);

        // 5: back-pressure pattern with random scores
        auto_exp = 1'b1;
        for (int i = 0; i < 10; i++) send($urandom_range(200) - 100, 100 + i, i == 9);
        drain(1, 100);

        // 6a: beat during drain is dropped
        send(40, 21, 0);
        send(60, 22, 0);
        send(50, 23, 1);
        hs = out_score; hi = out_id;
        in_valid = 1'b1; in_score = 100; in_id = 77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t6_drop_err", drop_err, 1);
        check("t6_hold_valid", out_valid, 1);
        check("t6_hold_score", out_score, hs);
        check("t6_hold_id", out_id, hi);
        drain(0, 50);
        send(4, 50, 1);
        drain(0, 50);
        check("t6_drop_sticky", drop_err, 1);

        // 6b: reset mid-drain discards table and output
        auto_exp = 1'b0;
        send(1, 1, 0);
        send(2, 2, 0);
        send(3, 3, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_drop", drop_err, 0);
        auto_exp = 1'b1;
        send(-5, 9, 1);
        drain(0, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
